// File: rtl/scan_sequencer.sv
// Scan-phase sequencer: walks steps 0..LAST_STEP, unpacks each 60-bit move packet
// into single move codes for the motor executor and requests a capture after each step.
// Optional build macro SCAN_TIMEOUT_EN adds a watchdog on the three wait states.
module scan_sequencer #(
  parameter int unsigned LAST_STEP      = 48,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        send_setup_moves,
  output logic [5:0]  counter,
  input  logic [59:0] moves,
  input  logic        new_moves,
  output logic        move_valid,
  output logic [3:0]  move_code,
  input  logic        move_ready,
  input  logic        move_done,
  output logic        capture_req,
  input  logic        capture_done,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT_PKT, S_SCAN, S_ISSUE,
    S_WAIT_DONE, S_CAPTURE, S_WAIT_CAP, S_FINISH
  } state_t;

  state_t      state_q;
  logic [5:0]  counter_q;
  logic [59:0] shreg_q;
  logic [3:0]  nib_cnt_q;
  logic        send_setup_moves_q;
  logic        move_valid_q;
  logic [3:0]  move_code_q;
  logic        capture_req_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [3:0]  top_nib;
  logic        wd_expired;

  assign top_nib = shreg_q[59:56];

`ifdef SCAN_TIMEOUT_EN
  logic [23:0] wd_q;
  logic        in_wait;

  assign in_wait    = (state_q == S_WAIT_PKT) || (state_q == S_WAIT_DONE) ||
                      (state_q == S_WAIT_CAP);
  assign wd_expired = in_wait && (wd_q == TIMEOUT_CYCLES - 24'd1);

  // Every path into a wait state passes through a non-wait state, which clears the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (in_wait) begin
      wd_q <= wd_q + 24'd1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      counter_q          <= '0;
      shreg_q            <= '0;
      nib_cnt_q          <= '0;
      send_setup_moves_q <= 1'b0;
      move_valid_q       <= 1'b0;
      move_code_q        <= '0;
      capture_req_q      <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      error_q            <= 1'b0;
    end else begin
      send_setup_moves_q <= 1'b0;
      capture_req_q      <= 1'b0;
      done_q             <= 1'b0;
      if (abort || wd_expired) begin
        state_q      <= S_IDLE;
        move_valid_q <= 1'b0;
        busy_q       <= 1'b0;
        if (wd_expired) error_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              counter_q          <= '0;
              error_q            <= 1'b0;
              state_q            <= S_REQ;
              busy_q             <= 1'b1;
              send_setup_moves_q <= 1'b1;
            end
          end
          S_REQ: state_q <= S_WAIT_PKT;
          S_WAIT_PKT: begin
            if (new_moves) begin
              shreg_q   <= moves;
              nib_cnt_q <= 4'd15;
              state_q   <= S_SCAN;
            end
          end
          S_SCAN: begin
            if (nib_cnt_q == 4'd0) begin
              if (counter_q < 6'(LAST_STEP)) begin
                state_q       <= S_CAPTURE;
                capture_req_q <= 1'b1;
              end else begin
                state_q <= S_FINISH;
                done_q  <= 1'b1;
              end
            end else if (top_nib == 4'd0) begin
              shreg_q   <= {shreg_q[55:0], 4'h0};
              nib_cnt_q <= nib_cnt_q - 4'd1;
            end else if ((top_nib == 4'd1) || (top_nib >= 4'd14)) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q      <= S_ISSUE;
              move_valid_q <= 1'b1;
              move_code_q  <= top_nib;
            end
          end
          S_ISSUE: begin
            if (move_ready) begin
              move_valid_q <= 1'b0;
              shreg_q      <= {shreg_q[55:0], 4'h0};
              nib_cnt_q    <= nib_cnt_q - 4'd1;
              state_q      <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: if (move_done) state_q <= S_SCAN;
          S_CAPTURE:   state_q <= S_WAIT_CAP;
          S_WAIT_CAP: begin
            if (capture_done) begin
              counter_q          <= counter_q + 6'd1;
              state_q            <= S_REQ;
              send_setup_moves_q <= 1'b1;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign send_setup_moves = send_setup_moves_q;
  assign counter          = counter_q;
  assign move_valid       = move_valid_q;
  assign move_code        = move_code_q;
  assign capture_req      = capture_req_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Top-level sequencer for the cube-scan phase. It walks the scan step index 0..48 into `spin_all`, requests each move packet and unpacks the 60-bit packet into single 4-bit move codes. It issues those codes one at a time to the motor executor over a valid/ready/done handshake, and triggers a colour-sensor capture after every observation step. It sits between the scan start command, `spin_all`, the motor move executor and the colour capture block.

## Interface

Parameters:
- `LAST_STEP`, default 48: final step index. This step issues moves only; no capture follows it.
- `TIMEOUT_CYCLES`, default 24'd10_000_000: watchdog limit in clock cycles. Used only with `SCAN_TIMEOUT_EN`.

Ports:
- `clock`  in  1  system clock. All logic is posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a scan. Ignored while `busy`.
- `abort`  in  1  synchronous abort. Returns the block to IDLE.
- `send_setup_moves`  out  1  one-cycle request to `spin_all`.
- `counter`  out  6  current step index to `spin_all`.
- `moves`  in  60  move packet from `spin_all`. Sampled only when `new_moves`=1.
- `new_moves`  in  1  packet-valid strobe from `spin_all`.
- `move_valid`  out  1  move offered to the motor executor.
- `move_code`  out  4  move code. Legal values are 2..13.
- `move_ready`  in  1  executor accepts the move when `move_valid`=1 and `move_ready`=1.
- `move_done`  in  1  one-cycle pulse when the physical move completes.
- `capture_req`  out  1  one-cycle pulse requesting a colour capture.
- `capture_done`  in  1  one-cycle pulse when the capture completes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the scan finishes.
- `error`  out  1  sticky. Cleared only by reset or by an accepted `start`.

## Operation

States: IDLE, REQ, WAIT_PKT, SCAN, ISSUE, WAIT_DONE, CAPTURE, WAIT_CAP, FINISH.

- **IDLE:** `start` sets `counter`=0, clears `error`, and moves to REQ.
- **REQ:** asserts `send_setup_moves` for exactly one cycle, then moves to WAIT_PKT.
- **WAIT_PKT:**
  - On `new_moves`, load `moves` into a 60-bit shift register, set nibble count to 15, and go to SCAN.
  - `counter` is held stable from REQ until the packet is loaded.
- **SCAN:** examines the top nibble, bits [59:56].
  - If nibble count = 0: go to CAPTURE when `counter` < `LAST_STEP`, otherwise go to FINISH.
  - If the nibble is 0: shift left 4 bits, decrement the count, and stay in SCAN (one cycle per nibble).
  - If the nibble is 1, 14 or 15: set `error` and go to IDLE.
  - Otherwise: go to ISSUE.
- **ISSUE:**
  - Drive `move_valid`=1 and `move_code` = top nibble, held until `move_ready`.
  - On acceptance: shift, decrement the count, and go to WAIT_DONE.
- **WAIT_DONE:** on `move_done`, return to SCAN.
- **CAPTURE:** pulses `capture_req` for one cycle, then moves to WAIT_CAP.
- **WAIT_CAP:** on `capture_done`, increment `counter` and go to REQ.
- **FINISH:** pulses `done` for one cycle, then moves to IDLE. `counter` stays at `LAST_STEP`.

Move order and packet rules:
- Moves are issued from the most significant nonzero nibble down to nibble 0.
- Zero nibbles are skipped anywhere in the packet.
- A packet containing only zeros issues nothing and proceeds straight to capture.

Boundary rules:
- **`abort` in any state:** next state is IDLE. `move_valid` and `capture_req` drop on the next edge, and `error` is unchanged. A move already accepted is not recalled. The executor finishes it and the `move_done` arrives while the block is in IDLE, where it is ignored.
- **`start` while busy:** ignored.
- **`start` and `abort` in the same cycle from IDLE:** `abort` wins, and the block stays in IDLE.
- **`move_done`, `capture_done` or `new_moves` in an unexpected state:** ignored.
- **`move_ready` and `move_done` in the same cycle:** `move_done` is ignored, because the block is still in ISSUE.

Reset values:
- State IDLE; `counter`=0.
- All outputs 0, including `move_code`=0.
- Shift register and nibble count = 0.

## Timing

- `start` at edge N: REQ at N+1, so `send_setup_moves`=1 during cycle N+1.
- `spin_all` returns `new_moves` two cycles after the request. The first SCAN cycle follows on the next edge.
- **Per zero nibble:** 1 cycle.
- **Per move:** 1 SCAN cycle, plus ISSUE until handshake, plus WAIT_DONE until `move_done`.
- **Step 0, packet 0x...837:** 12 skip cycles precede the first `move_valid`.
- **Step to step, after `capture_done`:** REQ is one cycle later.
- **`done` timing:** `done` asserts exactly 2 cycles after the last `move_done` of step 48 (SCAN, then FINISH).
- All outputs are registered.

## Configuration

`SCAN_TIMEOUT_EN`:
- **Defined:**
  - A 24-bit watchdog counts cycles spent in WAIT_PKT, WAIT_DONE or WAIT_CAP, and resets on every state change.
  - Reaching `TIMEOUT_CYCLES` sets `error`, drops all requests and enters IDLE.
- **Undefined:** no counter is built, and the wait states wait forever.

## Test plan

- **Step 0 issue order:** packet `moves`=60'h837 at step 0, executor always ready, `move_done` 3 cycles after each accept. Expect `move_code` sequence 8, 3, 7, then exactly one `capture_req`, then `counter`=1 with `send_setup_moves` pulsed once.
- **Full scan with real `spin_all`:** expect 49 `send_setup_moves` pulses, 48 `capture_req` pulses and 216 accepted moves in the `spin_all` table order. Expect a single `done` pulse with `counter`=48 and `error`=0.
- **Backpressure:** hold `move_ready`=0 for 10 cycles in ISSUE. `move_valid` and `move_code` stay stable, exactly one move is accepted, and no move is duplicated.
- **Illegal nibble:** packet 60'hF2. Expect `error`=1, no `move_valid` ever, state IDLE, and `busy`=0.
- **Abort mid-move:** `abort` during WAIT_DONE at step 5. Expect `busy`=0 next cycle, the later `move_done` ignored, and a fresh `start` restarting at `counter`=0.
- **Timeout (`SCAN_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=20):** withhold `capture_done`. Expect `error`=1 and IDLE 20 cycles after entering WAIT_CAP.
